axi_lite_rr_arbiter: RTL and testbench

N-master, single-slave AXI4-Lite arbiter with independent read and write arbitration, fair round-robin priority, and registered grants. It sits between the core's memory masters (IFU, LSU, and further DMA/debug masters) and the shared memory/peripheral bus. It replaces fixed-priority two-master arbitration: width and master count are parameters. Write address and write data are kept bound to the same granted master until its B response completes.

---
 rtl/axi_lite_rr_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_axi_lite_rr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rr_arbiter.sv
// rtl/axi_lite_rr_arbiter.sv - N-master to single-slave AXI4-Lite arbiter, independent round-robin read/write paths
module axi_lite_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  // master-side read channels
  input  logic [N_MASTERS-1:0]          m_arvalid,
  output logic [N_MASTERS-1:0]          m_arready,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
  output logic [N_MASTERS-1:0]          m_rvalid,
  input  logic [N_MASTERS-1:0]          m_rready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [N_MASTERS*2-1:0]        m_rresp,
  // master-side write channels
  input  logic [N_MASTERS-1:0]          m_awvalid,
  output logic [N_MASTERS-1:0]          m_awready,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
  input  logic [N_MASTERS-1:0]          m_wvalid,
  output logic [N_MASTERS-1:0]          m_wready,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wmask,
  output logic [N_MASTERS-1:0]          m_bvalid,
  input  logic [N_MASTERS-1:0]          m_bready,
  output logic [N_MASTERS*2-1:0]        m_bresp,
  // slave-side channels
  output logic [ADDR_W-1:0]             s_araddr,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  output logic [ADDR_W-1:0]             s_awaddr,
  output logic                          s_awvalid,
  input  logic                          s_awready,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wmask,
  output logic                          s_wvalid,
  input  logic                          s_wready,
  input  logic [1:0]                    s_bresp,
  input  logic                          s_bvalid,
  output logic                          s_bready
);

  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;

  rd_state_e        r_state_q, r_state_d;
  logic [IDX_W-1:0] rgnt_q, rgnt_d, rptr_q, rptr_d;
  wr_state_e        w_state_q, w_state_d;
  logic [IDX_W-1:0] wgnt_q, wgnt_d, wptr_q, wptr_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             aw_hs, w_hs;

  // First requester found scanning ptr, ptr+1, ... with wrap at N_MASTERS.
  // One extra bit on the sum keeps the wrap compare exact for non-power-of-two counts.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_MASTERS)) sum = sum - (IDX_W+1)'(N_MASTERS);
      if (!found && req[sum]) begin
        pick  = sum[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    return (int'(g) == N_MASTERS - 1) ? '0 : g + IDX_W'(1);
  endfunction

  // R data is shared by all masters; only the granted master sees m_rvalid.
  assign m_rdata = s_rdata;

  // Read path state, grant and fairness pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      rgnt_q    <= '0;
      rptr_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      rgnt_q    <= rgnt_d;
      rptr_q    <= rptr_d;
    end
  end

  // Read arbitration and channel routing to the granted master.
  always_comb begin
    r_state_d = r_state_q;
    rgnt_d    = rgnt_q;
    rptr_d    = rptr_q;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rresp   = '0;
    case (r_state_q)
      R_IDLE: begin
        if (|m_arvalid) begin
          rgnt_d    = rr_pick(m_arvalid, rptr_q);
          rptr_d    = rr_next(rgnt_d);
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        s_arvalid         = m_arvalid[rgnt_q];
        s_araddr          = m_araddr[rgnt_q*ADDR_W +: ADDR_W];
        m_arready[rgnt_q] = s_arready;
        if (s_arvalid && s_arready) r_state_d = R_RESP;
      end
      R_RESP: begin
        s_araddr                 = m_araddr[rgnt_q*ADDR_W +: ADDR_W];
        m_rvalid[rgnt_q]         = s_rvalid;
        s_rready                 = m_rready[rgnt_q];
        m_rresp[rgnt_q*2 +: 2]   = s_rresp;
        if (s_rvalid && s_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write path state, grant, pointer and per-channel completion flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      wgnt_q    <= '0;
      wptr_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wgnt_q    <= wgnt_d;
      wptr_q    <= wptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Write arbitration; AW and W stay bound to one master until its B completes.
  always_comb begin
    w_state_d = w_state_q;
    wgnt_d    = wgnt_q;
    wptr_d    = wptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wmask   = '0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    case (w_state_q)
      W_IDLE: begin
        if (|m_awvalid) begin
          wgnt_d    = rr_pick(m_awvalid, wptr_q);
          wptr_d    = rr_next(wgnt_d);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        s_awaddr          = m_awaddr[wgnt_q*ADDR_W +: ADDR_W];
        s_wdata           = m_wdata[wgnt_q*DATA_W +: DATA_W];
        s_wmask           = m_wmask[wgnt_q*STRB_W +: STRB_W];
        s_awvalid         = m_awvalid[wgnt_q] && !aw_done_q;
        s_wvalid          = m_wvalid[wgnt_q] && !w_done_q;
        m_awready[wgnt_q] = s_awready && !aw_done_q;
        m_wready[wgnt_q]  = s_wready && !w_done_q;
        aw_hs             = s_awvalid && s_awready;
        w_hs              = s_wvalid && s_wready;
        aw_done_d         = aw_done_q || aw_hs;
        w_done_d          = w_done_q || w_hs;
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        s_awaddr               = m_awaddr[wgnt_q*ADDR_W +: ADDR_W];
        s_wdata                = m_wdata[wgnt_q*DATA_W +: DATA_W];
        s_wmask                = m_wmask[wgnt_q*STRB_W +: STRB_W];
        m_bvalid[wgnt_q]       = s_bvalid;
        s_bready               = m_bready[wgnt_q];
        m_bresp[wgnt_q*2 +: 2] = s_bresp;
        if (s_bvalid && s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// tb/tb_axi_lite_rr_arbiter.sv - directed and randomized checks for axi_lite_rr_arbiter with N_MASTERS=3
module tb_axi_lite_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0]    m_arvalid = '0, m_arready, m_rvalid, m_rready = '0;
  logic [N*AW-1:0] m_araddr = '0, m_awaddr = '0;
  logic [DW-1:0]   m_rdata;
  logic [N*2-1:0]  m_rresp, m_bresp;
  logic [N-1:0]    m_awvalid = '0, m_awready, m_wvalid = '0, m_wready, m_bvalid, m_bready = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N*SW-1:0] m_wmask = '0;
  logic [AW-1:0]   s_araddr, s_awaddr;
  logic            s_arvalid, s_arready = 1'b0, s_rvalid = 1'b0, s_rready;
  logic [DW-1:0]   s_rdata = '0, s_wdata;
  logic [1:0]      s_rresp = '0, s_bresp = '0;
  logic            s_awvalid, s_awready = 1'b0, s_wvalid, s_wready = 1'b0, s_bvalid = 1'b0, s_bready;
  logic [SW-1:0]   s_wmask;

  always #5 clk = ~clk;

  axi_lite_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wmask(s_wmask), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // reference model / random traffic state
  bit          rd_free, wr_free;
  int          rptr_m, wptr_m, rown, wown, seq;
  bit          ar_pend[N], r_wait[N], wact[N], aw_pend[N], w_pend[N];
  int          aw_dly[N], w_dly[N], rd_cnt[N], wr_cnt[N];
  logic [31:0] ar_a[N], aw_a[N], w_d[N];
  logic [3:0]  w_m[N];
  int          rd_stage, rd_delay, b_stage, b_delay, aw_cnt, w_cnt, busy;
  logic [31:0] rd_addr, sw_awaddr;
  bit          sw_aw_got, sw_w_got;
  int          hs_aw, hs_w;

  initial begin
    // ---- reset state: all requests and slave handshakes high while held in reset
    m_arvalid = '1; m_awvalid = '1; m_wvalid = '1; m_rready = '1; m_bready = '1;
    for (int i = 0; i < N; i++) m_araddr[i*AW +: AW] = 32'h1000 + 32'h100 * i;
    m_awaddr = '1; m_wdata = '1; m_wmask = '1;
    s_arready = 1; s_rvalid = 1; s_rresp = 2'b11; s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b11;
    repeat (3) nxt();
    chk("rst_s_valid", {s_arvalid, s_awvalid, s_wvalid}, 0);
    chk("rst_s_ready", {s_rready, s_bready}, 0);
    chk("rst_m_ready", {m_arready, m_awready, m_wready}, 0);
    chk("rst_m_valid", {m_rvalid, m_bvalid}, 0);
    chk("rst_m_resp", {m_rresp, m_bresp}, 0);
    chk("rst_payload", {s_araddr, s_awaddr}, 0);
    m_awvalid = '0; m_wvalid = '0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0; s_rresp = 0;
    reset = 1;

    // ---- round robin with all three masters requesting continuously
    for (int k = 0; k < 6; k++) begin
      s_rvalid = 0;
      #1 chk("rr_idle_no_ar", s_arvalid, 0);
      nxt();
      #1 chk("rr_arvalid", s_arvalid, 1);
      chk("rr_araddr", s_araddr, 32'h1000 + 32'h100 * (k % 3));
      chk("rr_arready", m_arready, onehot(k % 3));
      nxt();
      s_rvalid = 1; s_rdata = 32'hA0 + k % 3;
      #1 chk("rr_rvalid", m_rvalid, onehot(k % 3));
      chk("rr_rdata", m_rdata, 32'hA0 + k % 3);
      chk("rr_rready", s_rready, 1);
      nxt();
    end
    s_rvalid = 0; m_arvalid = '0; s_arready = 0;
    nxt();

    // ---- write ordering: W two cycles ahead of AW, awready delayed
    m_wvalid = 3'b010; m_wdata = '0; m_wmask = '0; m_awaddr = '0;
    m_wdata[DW +: DW] = 32'hDEAD_BEEF; m_wmask[SW +: SW] = 4'hF; s_wready = 1; s_awready = 0;
    hs_aw = 0; hs_w = 0;
    for (int c = 0; c < 2; c++) begin
      #1 chk("wo_w_alone_no_req", {s_wvalid, m_wready}, 0);
      nxt();
    end
    m_awvalid = 3'b010; m_awaddr[AW +: AW] = 32'h1000_0004;
    #1 chk("wo_idle_no_aw", s_awvalid, 0);
    nxt();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) s_awready = 1;
      #1 chk("wo_awvalid", s_awvalid, 1);
      chk("wo_awaddr", s_awaddr, 32'h1000_0004);
      if (c == 0) begin
        chk("wo_wvalid", s_wvalid, 1);
        chk("wo_wpayload", {s_wmask, s_wdata}, {4'hF, 32'hDEAD_BEEF});
        chk("wo_wready", m_wready, 3'b010);
      end else begin
        chk("wo_w_gated", {s_wvalid, m_wready}, 0);
      end
      if (c == 3) chk("wo_awready", m_awready, 3'b010);
      hs_aw += int'(s_awvalid && s_awready);
      hs_w  += int'(s_wvalid && s_wready);
      nxt();
    end
    m_awvalid = '0; m_wvalid = '0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = 2'b00; m_bready = '1;
    #1 chk("wo_bvalid", m_bvalid, 3'b010);
    chk("wo_bresp", m_bresp, 0);
    chk("wo_bready", s_bready, 1);
    hs_w += int'(s_wvalid && s_wready);
    nxt();
    s_bvalid = 0;
    #1 chk("wo_b_done", {m_bvalid, s_awvalid}, 0);
    chk("wo_aw_once", hs_aw, 1);
    chk("wo_w_once", hs_w, 1);

    // ---- concurrent read (master 0) and write (master 1)
    m_arvalid = 3'b001; m_araddr[0 +: AW] = 32'h8000_0000;
    m_awvalid = 3'b010; m_wvalid = 3'b010; m_awaddr[AW +: AW] = 32'h1000_0004;
    m_wdata[DW +: DW] = 32'h1234_5678; m_wmask[SW +: SW] = 4'h3;
    s_arready = 1; s_awready = 1; s_wready = 1; m_rready = '1;
    #1 chk("cc_idle", {s_arvalid, s_awvalid}, 0);
    nxt();
    #1 chk("cc_ar", {s_arvalid, s_araddr, m_arready}, {1'b1, 32'h8000_0000, 3'b001});
    chk("cc_aw", {s_awvalid, s_awaddr, m_awready}, {1'b1, 32'h1000_0004, 3'b010});
    chk("cc_w", {s_wvalid, s_wdata}, {1'b1, 32'h1234_5678});
    nxt();
    m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
    s_rvalid = 1; s_rdata = 32'h11; s_rresp = 2'b10; s_bvalid = 1; s_bresp = 2'b01;
    #1 chk("cc_r", {m_rvalid, m_rresp, m_rdata}, {3'b001, 6'b000010, 32'h11});
    chk("cc_b", {m_bvalid, m_bresp}, {3'b010, 6'b000100});
    nxt();
    s_rvalid = 0; s_bvalid = 0; s_rresp = 0; s_bresp = 0;
    #1 chk("cc_done", {m_rvalid, m_bvalid}, 0);
    nxt();

    // ---- backpressure on R from master 0 while master 1 waits
    m_arvalid = 3'b001; m_araddr[0 +: AW] = 32'h2000;
    nxt();
    #1 chk("bp_ar", s_arvalid, 1);
    nxt();
    m_arvalid = 3'b010; m_araddr[AW +: AW] = 32'h3000; m_rready = '0; s_rvalid = 1; s_rdata = 32'h55;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_hold", {s_rready, s_arvalid, m_arready, m_rvalid}, {1'b0, 1'b0, 3'b000, 3'b001});
      nxt();
    end
    m_rready = 3'b001;
    #1 chk("bp_release", {s_rready, m_rvalid}, {1'b1, 3'b001});
    nxt();
    s_rvalid = 0;
    #1 chk("bp_idle", s_arvalid, 0);
    nxt();
    #1 chk("bp_next", {s_arvalid, s_araddr, m_arready}, {1'b1, 32'h3000, 3'b010});
    nxt();
    m_arvalid = '0; s_rvalid = 1; m_rready = '1;
    #1 chk("bp_next_r", m_rvalid, 3'b010);
    nxt();
    s_rvalid = 0; s_arready = 0;

    // ---- reset during W_ADDR after AW accepted
    m_awvalid = 3'b001; m_awaddr[0 +: AW] = 32'h4000; m_wvalid = 3'b001; m_wdata[0 +: DW] = 32'hCAFE;
    s_awready = 1; s_wready = 0;
    nxt();
    #1 chk("rw_aw_hs", s_awvalid, 1);
    nxt();
    #1 chk("rw_pre", {s_awvalid, s_wvalid}, 2'b01);
    reset = 0;
    #1 chk("rw_async", {s_awvalid, s_wvalid, m_wready}, 0);
    nxt();
    reset = 1; m_awvalid = 3'b101; m_awaddr[2*AW +: AW] = 32'h6000; s_awready = 0;
    #1 chk("rw_idle", s_awvalid, 0);
    nxt();
    #1 chk("rw_regrant", {s_awvalid, s_awaddr, s_wvalid}, {1'b1, 32'h4000, 1'b1});

    // ---- randomized traffic against the reference model
    reset = 0;
    m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; s_awready = 0; s_wready = 0;
    nxt(); nxt();
    reset = 1;
    rd_free = 1; wr_free = 1; rptr_m = 0; wptr_m = 0; rown = 0; wown = 0; seq = 1;
    rd_stage = 0; rd_delay = 0; b_stage = 0; b_delay = 0; aw_cnt = 0; w_cnt = 0;
    rd_addr = 0; sw_awaddr = 0; sw_aw_got = 0; sw_w_got = 0;
    for (int i = 0; i < N; i++) begin
      ar_pend[i] = 0; r_wait[i] = 0; wact[i] = 0; aw_pend[i] = 0; w_pend[i] = 0;
      aw_dly[i] = 0; w_dly[i] = 0; rd_cnt[i] = 0; wr_cnt[i] = 0;
      ar_a[i] = 0; aw_a[i] = 0; w_d[i] = 0; w_m[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        m_arvalid[i] = ar_pend[i];
        m_araddr[i*AW +: AW] = ar_a[i];
        m_rready[i] = ($urandom % 4) != 0;
        m_awvalid[i] = aw_pend[i] && aw_dly[i] == 0;
        m_awaddr[i*AW +: AW] = aw_a[i];
        m_wvalid[i] = w_pend[i] && w_dly[i] == 0;
        m_wdata[i*DW +: DW] = w_d[i];
        m_wmask[i*SW +: SW] = w_m[i];
        m_bready[i] = ($urandom % 4) != 0;
      end
      s_arready = ($urandom % 3) != 0;
      s_rvalid = rd_stage == 2; s_rdata = rdata_of(rd_addr); s_rresp = rd_addr[3:2];
      s_awready = ($urandom % 3) != 0; s_wready = ($urandom % 3) != 0;
      s_bvalid = b_stage == 2; s_bresp = sw_awaddr[3:2];
      #1;
      if (rd_free) begin
        chk("rd_idle", {s_arvalid, m_arready, m_rvalid}, 0);
        if (|m_arvalid) begin
          rown = rr_pick(rptr_m, m_arvalid); rptr_m = (rown + 1) % N; rd_free = 0;
        end
      end else begin
        chk("rd_route", (m_arready | m_rvalid) & ~onehot(rown), 0);
        if (s_arvalid && s_arready) chk("rd_araddr", s_araddr, ar_a[rown]);
      end
      if (wr_free) begin
        chk("wr_idle", {s_awvalid, s_wvalid, m_awready, m_wready, m_bvalid}, 0);
        if (|m_awvalid) begin
          wown = rr_pick(wptr_m, m_awvalid); wptr_m = (wown + 1) % N; wr_free = 0;
        end
      end else begin
        chk("wr_route", (m_awready | m_wready | m_bvalid) & ~onehot(wown), 0);
        if (s_awvalid && s_awready) begin chk("wr_awaddr", s_awaddr, aw_a[wown]); aw_cnt++; end
        if (s_wvalid && s_wready) begin chk("wr_wdata", {s_wmask, s_wdata}, {w_m[wown], w_d[wown]}); w_cnt++; end
      end
      for (int i = 0; i < N; i++) begin
        if (m_arvalid[i] && m_arready[i]) begin ar_pend[i] = 0; r_wait[i] = 1; end
        if (m_rvalid[i] && m_rready[i]) begin
          chk("rd_expected", r_wait[i], 1);
          chk("rd_data_m", {m_rresp[i*2 +: 2], m_rdata}, {ar_a[i][3:2], rdata_of(ar_a[i])});
          r_wait[i] = 0; rd_cnt[i]++;
        end
        if (m_awvalid[i] && m_awready[i]) aw_pend[i] = 0;
        if (m_wvalid[i] && m_wready[i]) w_pend[i] = 0;
        if (m_bvalid[i] && m_bready[i]) begin
          chk("wr_b_expected", {wact[i], aw_pend[i], w_pend[i]}, 3'b100);
          chk("wr_bresp_m", m_bresp[i*2 +: 2], aw_a[i][3:2]);
          wact[i] = 0; wr_cnt[i]++;
        end
      end
      if (s_rvalid && s_rready) begin rd_stage = 0; rd_free = 1; end
      if (rd_stage == 1) begin rd_delay--; if (rd_delay == 0) rd_stage = 2; end
      if (s_arvalid && s_arready) begin
        rd_addr = s_araddr; rd_delay = $urandom_range(0, 3); rd_stage = (rd_delay == 0) ? 2 : 1;
      end
      if (s_bvalid && s_bready) begin
        chk("wr_aw_once", aw_cnt, 1); chk("wr_w_once", w_cnt, 1);
        aw_cnt = 0; w_cnt = 0; b_stage = 0; sw_aw_got = 0; sw_w_got = 0; wr_free = 1;
      end
      if (b_stage == 1) begin b_delay--; if (b_delay == 0) b_stage = 2; end
      if (s_awvalid && s_awready) begin sw_awaddr = s_awaddr; sw_aw_got = 1; end
      if (s_wvalid && s_wready) sw_w_got = 1;
      if (b_stage == 0 && sw_aw_got && sw_w_got) begin
        b_delay = $urandom_range(0, 2); b_stage = (b_delay == 0) ? 2 : 1;
      end
      for (int i = 0; i < N; i++) begin
        if (aw_dly[i] > 0) aw_dly[i]--;
        if (w_dly[i] > 0) w_dly[i]--;
        if (cyc < 2500 && !ar_pend[i] && !r_wait[i] && ($urandom % 3) == 0) begin
          ar_pend[i] = 1; ar_a[i] = {4'(i + 1), 28'(seq * 4)}; seq++;
        end
        if (cyc < 2500 && !wact[i] && ($urandom % 3) == 0) begin
          wact[i] = 1; aw_pend[i] = 1; w_pend[i] = 1;
          aw_dly[i] = $urandom_range(0, 2); w_dly[i] = $urandom_range(0, 2);
          aw_a[i] = {4'(i + 9), 28'(seq * 4)}; seq++;
          w_d[i] = $urandom; w_m[i] = 4'($urandom);
        end
      end
      nxt();
    end
    busy = 0;
    for (int i = 0; i < N; i++) busy += int'(ar_pend[i]) + int'(r_wait[i]) + int'(wact[i]);
    chk("rand_drained", busy, 0);
    for (int i = 0; i < N; i++) begin
      chk("rand_rd_served", rd_cnt[i] > 0, 1);
      chk("rand_wr_served", wr_cnt[i] > 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
